// File: rtl/cliffwalk_episode_driver_pkg.sv
// rtl/cliffwalk_episode_driver_pkg.sv - shared constants and types for the cliffwalk episode driver
// Purpose: CliffWalking grid constants, action codes, FSM state encoding and
//          the 16-bit Fibonacci LFSR step function (taps 16,14,13,11).
// Ports:   none (package).
package cliffwalk_episode_driver_pkg;

  localparam int unsigned GRID_START = 36;
  localparam int unsigned GRID_GOAL  = 47;
  localparam int unsigned GRID_COLS  = 12;
  localparam int unsigned GRID_ROWS  = 4;

  localparam logic [1:0] ACT_UP    = 2'd0;
  localparam logic [1:0] ACT_RIGHT = 2'd1;
  localparam logic [1:0] ACT_DOWN  = 2'd2;
  localparam logic [1:0] ACT_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_REPORT = 2'd2
  } fsm_state_e;

  // Shift left, feedback from taps 16,14,13,11 (bits 15,13,12,10) into bit 0.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/cliffwalk_episode_driver_lfsr16.sv
// rtl/cliffwalk_episode_driver_lfsr16.sv - 16-bit Fibonacci LFSR action source
// Purpose: pseudo-random action source; seeded only by reset, advances on i_adv.
// Ports:   i_clk, i_rst_n (async active-low), i_adv (advance one step),
//          o_val (current 16-bit register value).
module lfsr16
  import cliffwalk_episode_driver_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_adv,
  output logic [15:0] o_val
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_adv) lfsr_d = lfsr16_next(lfsr_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign o_val = lfsr_q;

endmodule

// File: rtl/cliffwalk_episode_driver.sv
// rtl/cliffwalk_episode_driver.sv - drives one CliffWalking episode against an external environment
// Purpose: IDLE/STEP/REPORT sequencer. In STEP it presents state and action to
//          the environment, accepts a response whenever i_env_valid is high,
//          counts steps and cliff falls, and ends on goal or on MAX_STEPS.
// Ports:   i_clk/i_rst_n clock and async active-low reset; i_start episode start;
//          i_force_en/i_force_act scripted action override;
//          o_env_ena/o_sta/o_act step request; i_env_obs/i_env_rwd/i_env_done/
//          i_env_valid environment response; o_busy status;
//          o_ep_valid/i_ep_ready/o_ep_steps/o_ep_falls/o_ep_goal episode report.
module cliffwalk_episode_driver
  import cliffwalk_episode_driver_pkg::*;
#(
  parameter int          STA_WL    = 32,
  parameter int          ACT_WL    = 2,
  parameter int          RWD_WL    = 1,
  parameter int          CNT_WL    = 16,
  parameter int          MAX_STEPS = 100,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_force_en,
  input  logic [ACT_WL-1:0] i_force_act,
  output logic              o_env_ena,
  output logic [STA_WL-1:0] o_sta,
  output logic [ACT_WL-1:0] o_act,
  input  logic [STA_WL-1:0] i_env_obs,
  input  logic [RWD_WL-1:0] i_env_rwd,
  input  logic              i_env_done,
  input  logic              i_env_valid,
  output logic              o_busy,
  output logic              o_ep_valid,
  input  logic              i_ep_ready,
  output logic [CNT_WL-1:0] o_ep_steps,
  output logic [CNT_WL-1:0] o_ep_falls,
  output logic              o_ep_goal
);

  fsm_state_e state_q, state_d;

  logic [STA_WL-1:0] sta_q, sta_d;
  logic [CNT_WL-1:0] steps_q, steps_d;
  logic [CNT_WL-1:0] falls_q, falls_d;
  logic              goal_q, goal_d;

  logic [15:0]       lfsr_val;
  logic              lfsr_unused;
  logic              step_acc;
  logic              is_fall;
  logic              hit_max;
  logic [CNT_WL-1:0] steps_inc;
  logic [CNT_WL-1:0] falls_inc;

  assign step_acc  = (state_q == ST_STEP) && i_env_valid;
  assign is_fall   = (i_env_rwd == RWD_WL'(1));
  // Counters stick at all-ones instead of wrapping.
  assign steps_inc = (&steps_q) ? steps_q : steps_q + CNT_WL'(1);
  assign falls_inc = (&falls_q) ? falls_q : falls_q + CNT_WL'(1);
  assign hit_max   = (steps_inc >= CNT_WL'(MAX_STEPS));

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_adv   (step_acc),
    .o_val   (lfsr_val)
  );

  assign lfsr_unused = ^lfsr_val[15:ACT_WL];

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state. Goal outranks truncation when both land on one step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_start) state_d = ST_STEP;
      ST_STEP:   if (step_acc && (i_env_done || hit_max)) state_d = ST_REPORT;
      ST_REPORT: if (i_ep_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_env_ena  = (state_q == ST_STEP);
    o_busy     = (state_q != ST_IDLE);
    o_ep_valid = (state_q == ST_REPORT);
  end

  // Episode datapath: loaded on start, updated only on accepted steps.
  always_comb begin
    sta_d   = sta_q;
    steps_d = steps_q;
    falls_d = falls_q;
    goal_d  = goal_q;
    if ((state_q == ST_IDLE) && i_start) begin
      sta_d   = STA_WL'(GRID_START);
      steps_d = '0;
      falls_d = '0;
      goal_d  = 1'b0;
    end else if (step_acc) begin
      sta_d   = i_env_obs;
      steps_d = steps_inc;
      if (is_fall)    falls_d = falls_inc;
      if (i_env_done) goal_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sta_q   <= STA_WL'(GRID_START);
      steps_q <= '0;
      falls_q <= '0;
      goal_q  <= 1'b0;
    end else begin
      sta_q   <= sta_d;
      steps_q <= steps_d;
      falls_q <= falls_d;
      goal_q  <= goal_d;
    end
  end

  assign o_sta      = sta_q;
  assign o_act      = i_force_en ? i_force_act : lfsr_val[ACT_WL-1:0];
  assign o_ep_steps = steps_q;
  assign o_ep_falls = falls_q;
  assign o_ep_goal  = goal_q;

endmodule
